// File: rtl/mtrx_pkg.sv
// ---------------------------------------------------------------------------
// mtrx_pkg
// Shared definitions for the packed-matrix datapath: matrix geometry, bus
// width, serializer state encoding and the row/col marker that tags the
// checksum beat.
//
// Configuration macro: MTRX_SERIALIZER_CHECKSUM_EN adds the CSUM state.
// ---------------------------------------------------------------------------
package mtrx_pkg;

    localparam int MTRX_N     = 5;
    localparam int MTRX_W     = 8;
    localparam int MTRX_BUS_W = MTRX_N * MTRX_N * MTRX_W;

    // Row/col value reported on the checksum beat; never a legal index for N=5.
    localparam logic [2:0] MTRX_CSUM_IDX = 3'd7;

`ifdef MTRX_SERIALIZER_CHECKSUM_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CSUM = 2'd2
    } mtrx_state_t;
`else
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } mtrx_state_t;
`endif

endpackage

// File: rtl/mtrx_elem_index.sv
// ---------------------------------------------------------------------------
// mtrx_elem_index
// Row-major (row,col) element counter for an N x N matrix. Advances one
// element per enabled cycle, wraps col at N-1 (bumping row), and wraps the
// whole matrix back to (0,0) after (N-1,N-1). Shared by the serializer and
// the future deserializer.
//
// Ports:
//   clock      system clock
//   reset      synchronous active-low reset
//   i_clear    return to (0,0) on the next edge (wins over i_advance)
//   i_advance  step to the next element
//   o_row      current row index
//   o_col      current column index
//   o_first    current element is (0,0)
//   o_last     current element is (N-1,N-1)
// ---------------------------------------------------------------------------
module mtrx_elem_index #(
    parameter int N = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_advance,
    output logic [2:0] o_row,
    output logic [2:0] o_col,
    output logic       o_first,
    output logic       o_last
);

    localparam logic [2:0] LP_MAX = 3'(N - 1);

    logic [2:0] r_row;
    logic [2:0] r_col;

    // Index register: clear has priority so a fresh load always restarts at
    // (0,0), even on the same edge that accepts the previous matrix's last beat.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_advance) begin
            if (r_col == LP_MAX) begin
                r_col <= '0;
                r_row <= (r_row == LP_MAX) ? 3'd0 : r_row + 3'd1;
            end else begin
                r_col <= r_col + 3'd1;
            end
        end
    end

    assign o_row   = r_row;
    assign o_col   = r_col;
    assign o_first = (r_row == 3'd0) && (r_col == 3'd0);
    assign o_last  = (r_row == LP_MAX) && (r_col == LP_MAX);

endmodule

// File: rtl/mtrx_serializer.sv
// ---------------------------------------------------------------------------
// mtrx_serializer
// Accepts one packed N x N matrix of W-bit elements on a valid/ready load
// port, holds it in a shadow register and streams it out one element per
// beat in row-major order on a valid/ready byte stream. A new matrix may be
// loaded on the same edge that accepts the last beat, so back-to-back
// matrices stream with no bubble.
//
// Configuration macro: MTRX_SERIALIZER_CHECKSUM_EN appends one beat carrying
// the modulo-2^W sum of all elements, tagged with row=col=7.
//
// Ports:
//   clock, reset   system clock, synchronous active-low reset
//   in_valid       in_matrix holds a matrix to serialize
//   in_ready       a matrix can be accepted this cycle
//   in_matrix      packed matrix, element (r,c) at [(r*N+c)*W +: W]
//   out_valid      out_data holds a valid element
//   out_ready      sink accepts the current beat
//   out_data       current element
//   out_row/col    index of current element
//   out_first      current beat is element (0,0)
//   out_last       current beat is the final beat of the matrix
// ---------------------------------------------------------------------------
module mtrx_serializer
    import mtrx_pkg::*;
#(
    parameter int N = MTRX_N,
    parameter int W = MTRX_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*N*W-1:0] in_matrix,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [2:0]       out_row,
    output logic [2:0]       out_col,
    output logic             out_first,
    output logic             out_last
);

    localparam int LP_BASE_W = $clog2(N * N * W);

    mtrx_state_t          r_state;
    mtrx_state_t          w_nextState;
    logic [N*N*W-1:0]     r_shadow;
    logic [2:0]           w_row;
    logic [2:0]           w_col;
    logic                 w_idxFirst;
    logic                 w_idxLast;
    logic                 w_beatFire;
    logic                 w_load;
    logic                 w_advance;
    logic [LP_BASE_W-1:0] w_bitBase;

    assign w_beatFire = out_valid && out_ready;
    assign in_ready   = (r_state == IDLE) || (w_beatFire && out_last);
    assign w_load     = in_valid && in_ready;
    assign w_advance  = w_beatFire && (r_state == SEND);
    assign w_bitBase  = LP_BASE_W'((int'(w_row) * N + int'(w_col)) * W);

    mtrx_elem_index #(.N(N)) u_index (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (w_load),
        .i_advance(w_advance),
        .o_row    (w_row),
        .o_col    (w_col),
        .o_first  (w_idxFirst),
        .o_last   (w_idxLast)
    );

`ifdef MTRX_SERIALIZER_CHECKSUM_EN
    logic [W-1:0] r_csum;
    logic [W-1:0] w_inSum;

    // Sum is formed from the incoming bus so it is ready alongside the shadow
    // copy; the adder wraps naturally to give the modulo-2^W result.
    always_comb begin
        w_inSum = '0;
        for (int e = 0; e < N * N; e++) begin
            w_inSum = w_inSum + in_matrix[e*W +: W];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_csum <= '0;
        end else if (w_load) begin
            r_csum <= w_inSum;
        end
    end
`endif

    // Shadow copy decouples the stream from in_matrix, which the upstream
    // block is free to change once the load handshake has completed.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_shadow <= '0;
        end else if (w_load) begin
            r_shadow <= in_matrix;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A load always lands in SEND (including the back-to-back case); otherwise
    // accepting the final beat returns to IDLE. With the checksum enabled, the
    // last element hands over to the extra CSUM beat instead of finishing.
    always_comb begin
        w_nextState = r_state;
        if (w_load) begin
            w_nextState = SEND;
        end else if (w_beatFire && out_last) begin
            w_nextState = IDLE;
`ifdef MTRX_SERIALIZER_CHECKSUM_EN
        end else if ((r_state == SEND) && w_beatFire && w_idxLast) begin
            w_nextState = CSUM;
`endif
        end
    end

    // Output decode: everything is zero in IDLE, so the reset state and the
    // idle gap between matrices look identical to the sink.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_row   = '0;
        out_col   = '0;
        out_first = 1'b0;
        out_last  = 1'b0;
        case (r_state)
            SEND: begin
                out_valid = 1'b1;
                out_data  = r_shadow[w_bitBase +: W];
                out_row   = w_row;
                out_col   = w_col;
                out_first = w_idxFirst;
`ifdef MTRX_SERIALIZER_CHECKSUM_EN
                out_last  = 1'b0;
`else
                out_last  = w_idxLast;
`endif
            end
`ifdef MTRX_SERIALIZER_CHECKSUM_EN
            CSUM: begin
                out_valid = 1'b1;
                out_data  = r_csum;
                out_row   = MTRX_CSUM_IDX;
                out_col   = MTRX_CSUM_IDX;
                out_last  = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mtrx_serializer.sv
// ---------------------------------------------------------------------------
// tb_mtrx_serializer
// Self-checking bench for mtrx_serializer. Expected beats come from a
// row-major model: beat k of a matrix is element (k/5, k%5), optionally
// followed by the modulo-256 sum of all 25 elements.
// ---------------------------------------------------------------------------
module tb_mtrx_serializer;

`ifdef MTRX_SERIALIZER_CHECKSUM_EN
    localparam int LP_BEATS = 26;
`else
    localparam int LP_BEATS = 25;
`endif

    logic         clock;
    logic         reset;
    logic         inValid;
    logic         inReady;
    logic [199:0] inMatrix;
    logic         outValid;
    logic         outReady;
    logic [7:0]   outData;
    logic [2:0]   outRow;
    logic [2:0]   outCol;
    logic         outFirst;
    logic         outLast;

    int nChecks = 0;
    int nFails  = 0;

    mtrx_serializer dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (inValid),
        .in_ready (inReady),
        .in_matrix(inMatrix),
        .out_valid(outValid),
        .out_ready(outReady),
        .out_data (outData),
        .out_row  (outRow),
        .out_col  (outCol),
        .out_first(outFirst),
        .out_last (outLast)
    );

    // 100 MHz clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard time limit so a stuck design can never hang the run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached, required end of test");
        $fatal(1, "[TB] time limit exceeded");
    end

    // Reference beat {valid, data, row, col, first, last} for beat k of m.
    function automatic logic [16:0] expectedBeat(input logic [199:0] m, input int k);
        logic [7:0] d;
        logic [2:0] r;
        logic [2:0] c;
        int         sum;
        int         row;
        int         col;
        if (k < 25) begin
            row = k / 5;
            col = k % 5;
            d   = m[(row * 5 + col) * 8 +: 8];
            r   = 3'(row);
            c   = 3'(col);
        end else begin
            sum = 0;
            for (int e = 0; e < 25; e++) sum += int'(m[e*8 +: 8]);
            d = 8'(sum % 256);
            r = 3'd7;
            c = 3'd7;
        end
        return {1'b1, d, r, c, (k == 0), (k == LP_BEATS - 1)};
    endfunction

    function automatic logic [199:0] randMatrix();
        logic [199:0] m;
        for (int e = 0; e < 25; e++) m[e*8 +: 8] = 8'($urandom);
        return m;
    endfunction

    function automatic logic [199:0] altMatrix();
        logic [199:0] m;
        for (int e = 0; e < 25; e++) m[e*8 +: 8] = (e % 2 == 0) ? 8'd1 : 8'd2;
        return m;
    endfunction

    function automatic logic [199:0] constMatrix(input logic [7:0] v);
        logic [199:0] m;
        for (int e = 0; e < 25; e++) m[e*8 +: 8] = v;
        return m;
    endfunction

    function automatic logic [16:0] observed();
        return {outValid, outData, outRow, outCol, outFirst, outLast};
    endfunction

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    // Present a matrix until accepted; afterwards beat 0 is on the outputs.
    task automatic applyStimulus(input logic [199:0] m);
        int guard;
        guard    = 0;
        inValid  = 1'b1;
        inMatrix = m;
        #1;
        while (inReady !== 1'b1 && guard < 100) begin
            stepCycle();
            guard++;
        end
        if (guard >= 100) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL load_timeout: in_ready=%b, required 1", inReady);
        end
        stepCycle();
        inValid = 1'b0;
    endtask

    task automatic test_reset();
        logic [16:0] obs;
        reset    = 1'b0;
        inValid  = 1'b1;
        inMatrix = randMatrix();
        outReady = 1'b1;
        for (int i = 0; i < 2; i++) begin
            stepCycle();
            obs = observed();
            nChecks++;
            if (obs !== 17'd0) begin
                nFails++;
                $display("[TB] FAIL reset_outputs cyc=%0d: got %h, required %h", i, obs, 17'd0);
            end
        end
        inValid = 1'b0;
        reset   = 1'b1;
        stepCycle();
        obs = observed();
        nChecks++;
        if (obs !== 17'd0 || inReady !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL idle_after_reset: got beat %h ready %b, required 0 / 1", obs, inReady);
        end
    endtask

    task automatic test_basic_stream();
        logic [199:0] m;
        logic [16:0]  exp;
        logic [16:0]  obs;
        m        = altMatrix();
        outReady = 1'b1;
        applyStimulus(m);
        for (int k = 0; k < LP_BEATS; k++) begin
            exp = expectedBeat(m, k);
            obs = observed();
            nChecks++;
            if (obs !== exp) begin
                nFails++;
                $display("[TB] FAIL basic_beat k=%0d: got %h, required %h", k, obs, exp);
            end
            stepCycle();
        end
        obs = observed();
        nChecks++;
        if (obs !== 17'd0) begin
            nFails++;
            $display("[TB] FAIL basic_drop: got %h, required %h", obs, 17'd0);
        end
    endtask

    task automatic test_backpressure();
        logic [199:0] m;
        logic [16:0]  exp;
        logic [16:0]  obs;
        int           k;
        int           cyc;
        m   = altMatrix();
        k   = 0;
        cyc = 0;
        outReady = 1'b1;
        applyStimulus(m);
        while (k < LP_BEATS && cyc < 400) begin
            outReady = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (cyc == 7) inMatrix = constMatrix(8'hFF);
            #1;
            exp = expectedBeat(m, k);
            obs = observed();
            nChecks++;
            if (obs !== exp) begin
                nFails++;
                $display("[TB] FAIL stall_beat k=%0d cyc=%0d: got %h, required %h", k, cyc, obs, exp);
            end
            if (outReady) k++;
            stepCycle();
            cyc++;
        end
        nChecks++;
        if (k < LP_BEATS || observed() !== 17'd0) begin
            nFails++;
            $display("[TB] FAIL stall_end: beats=%0d valid=%b, required %0d / 0", k, outValid, LP_BEATS);
        end
    endtask

    task automatic test_back_to_back();
        logic [199:0] mA;
        logic [199:0] mB;
        logic [16:0]  exp;
        logic [16:0]  obs;
        mA       = randMatrix();
        mB       = constMatrix(8'd3);
        outReady = 1'b1;
        applyStimulus(mA);
        for (int k = 0; k < LP_BEATS; k++) begin
            if (k == LP_BEATS - 1) begin
                inValid  = 1'b1;
                inMatrix = mB;
                #1;
                nChecks++;
                if (inReady !== 1'b1) begin
                    nFails++;
                    $display("[TB] FAIL b2b_ready: got %b, required 1", inReady);
                end
            end
            exp = expectedBeat(mA, k);
            obs = observed();
            nChecks++;
            if (obs !== exp) begin
                nFails++;
                $display("[TB] FAIL b2b_first_k=%0d: got %h, required %h", k, obs, exp);
            end
            stepCycle();
        end
        inValid = 1'b0;
        for (int k = 0; k < LP_BEATS; k++) begin
            exp = expectedBeat(mB, k);
            obs = observed();
            nChecks++;
            if (obs !== exp) begin
                nFails++;
                $display("[TB] FAIL b2b_second k=%0d: got %h, required %h", k, obs, exp);
            end
            stepCycle();
        end
        nChecks++;
        if (observed() !== 17'd0) begin
            nFails++;
            $display("[TB] FAIL b2b_drop: got %h, required %h", observed(), 17'd0);
        end
    endtask

    task automatic test_reset_midstream();
        logic [199:0] m;
        logic [16:0]  exp;
        logic [16:0]  obs;
        m        = randMatrix();
        outReady = 1'b1;
        applyStimulus(m);
        for (int k = 0; k < 10; k++) stepCycle();
        reset = 1'b0;
        stepCycle();
        obs = observed();
        nChecks++;
        if (obs !== 17'd0) begin
            nFails++;
            $display("[TB] FAIL midreset_outputs: got %h, required %h", obs, 17'd0);
        end
        reset = 1'b1;
        m     = randMatrix();
        applyStimulus(m);
        for (int k = 0; k < LP_BEATS; k++) begin
            exp = expectedBeat(m, k);
            obs = observed();
            nChecks++;
            if (obs !== exp) begin
                nFails++;
                $display("[TB] FAIL midreset_reload k=%0d: got %h, required %h", k, obs, exp);
            end
            stepCycle();
        end
    endtask

    task automatic test_random_streams();
        logic [199:0] m;
        logic [16:0]  exp;
        logic [16:0]  obs;
        int           k;
        int           cyc;
        for (int n = 0; n < 4; n++) begin
            m   = randMatrix();
            k   = 0;
            cyc = 0;
            outReady = 1'b1;
            applyStimulus(m);
            while (k < LP_BEATS && cyc < 500) begin
                outReady = 1'($urandom_range(0, 1));
                inMatrix = randMatrix();
                #1;
                exp = expectedBeat(m, k);
                obs = observed();
                nChecks++;
                if (obs !== exp) begin
                    nFails++;
                    $display("[TB] FAIL random_beat n=%0d k=%0d: got %h, required %h", n, k, obs, exp);
                end
                if (outReady) k++;
                stepCycle();
                cyc++;
            end
            nChecks++;
            if (k < LP_BEATS || observed() !== 17'd0) begin
                nFails++;
                $display("[TB] FAIL random_end n=%0d: beats=%0d valid=%b, required %0d / 0", n, k, outValid, LP_BEATS);
            end
        end
    endtask

    // Scenario sequence; each task checks its own results.
    initial begin
        reset    = 1'b0;
        inValid  = 1'b0;
        inMatrix = '0;
        outReady = 1'b0;
        test_reset();
        test_basic_stream();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        test_random_streams();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/mtrx_serializer.md
Name: mtrx_serializer

Overview:
- Consumes one packed 5x5 matrix of 8-bit elements (200-bit bus, the same layout the matrix multiplier produces on c) through a valid/ready load handshake.
- Streams the matrix out one element per beat on an 8-bit valid/ready byte stream, in row-major order.
- Sits downstream of the multiplier and feeds the UART/host-readback path. It is the reading end of the packed-matrix interface.

Parameters:
- N, 5, matrix dimension; elements = N*N.
- W, 8, element width in bits; input bus width = N*N*W.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset, sampled on rising edge of clock.
- in_valid  input  1  in_matrix holds a matrix to serialize.
- in_ready  output  1  block can accept a matrix this cycle.
- in_matrix  input  N*N*W  packed matrix; element (row,col) at bits [(row*N+col)*W +: W].
- out_valid  output  1  out_data holds a valid element.
- out_ready  input  1  sink accepts the current beat.
- out_data  output  W  current element.
- out_row  output  3  row index of current element.
- out_col  output  3  column index of current element.
- out_first  output  1  current beat is element (0,0).
- out_last  output  1  current beat is the final beat of the matrix.

Behaviour:
- Reset (reset==0 at a clock edge) forces the following, overriding everything else including a mid-stream matrix, which is discarded:
  - state=IDLE, out_valid=0, out_data=0, out_row=0, out_col=0, out_first=0, out_last=0.
  - shadow register cleared.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). This is combinational from out_ready and allows back-to-back matrices with no bubble.
- Load: when in_valid && in_ready, in_matrix is copied into a 200-bit shadow register, state goes to SEND, and out_valid=1 from the next cycle with element (0,0).
- Load latency is 1 cycle, from the load edge to the first beat valid.
- SEND:
  - out_data = shadow[(out_row*N+out_col)*W +: W].
  - The beat advances only on out_valid && out_ready.
  - out_col increments and wraps to 0 at N-1, at which point out_row increments.
- While out_valid && !out_ready, out_data/out_row/out_col/out_first/out_last hold stable. in_matrix changes are ignored (the data comes from the shadow register).
- out_first = (out_row==0 && out_col==0) while in SEND.
- out_last is asserted on beat (N-1,N-1), or on the checksum beat when the optional feature is enabled.
- Last beat accepted with in_valid=1: the new matrix loads on the same edge, indices reset to (0,0), and out_valid stays 1.
- Last beat accepted with in_valid=0: state=IDLE and out_valid=0.
- Throughput: N*N beats per matrix with out_ready tied high.
- No arithmetic on data; elements pass bit-exact.

Optional Feature:
- Macro: MTRX_SERIALIZER_CHECKSUM_EN.
- Defined:
  - After element (N-1,N-1), one extra beat carries the 8-bit modulo-256 sum of all N*N elements.
  - The sum is accumulated at load time from in_matrix and registered with the shadow.
  - On the checksum beat, out_row=out_col=7 (marker value) and out_last=1 only on this beat.
  - Total N*N+1 beats per matrix.
- Undefined: no checksum logic or extra state; N*N beats, out_last on (N-1,N-1).

Decomposition:
- Shared package mtrx_pkg:
  - MTRX_N=5 and MTRX_W=8.
  - MTRX_BUS_W=200.
  - State enum {IDLE, SEND}, plus CSUM when the feature is enabled.
  - Checksum marker index 3'd7.
- One natural sub-module: mtrx_elem_index. It is the row/col counter with enable, wrap and last detection, and is reusable by the future deserializer.

Test Plan:
- Reset: reset=0 for 2 cycles while in_valid=1 -> in_ready ignored; out_valid=0, out_data=0, out_row/out_col=0.
- Basic stream: load the alternating 1/2 matrix (element (0,0)=1, (0,1)=2, ...) with out_ready=1 -> 25 beats on consecutive cycles:
  - data 1,2,1,2,... row-major.
  - out_first only on beat 0; out_last only on beat 24 with row=4, col=4.
  - out_valid drops the cycle after.
- Backpressure: same matrix with out_ready toggled 1,0,0,1,... and in_matrix changed to all-0xFF mid-stream -> data held stable during stalls; the sequence matches the original matrix; no beats lost or duplicated.
- Back-to-back: second matrix (all 8'd3) presented with in_valid=1 during the final beat -> element (0,0)=3 appears on the cycle immediately after beat 24, with no bubble and out_first=1.
- Reset mid-stream: assert reset at beat 10 -> the next cycle is IDLE with outputs zeroed; a fresh load restarts at (0,0).
- Checksum (macro defined): alternating 1/2 matrix -> 26 beats; beat 25 carries data=8'h25 (37), row=col=7, out_last=1; beat 24 has out_last=0.
